// File: rtl/data_memory_param.sv
// data_memory_param: single-port word memory with a power-up clear sweep; define DMEM_WRFWD_EN for write-first forwarding on same-address read/write
module data_memory_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writedata,
  input  logic                  memread,
  input  logic                  memwrite,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readvalid,
  output logic                  ready
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  logic [0:0] state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  assign ready = state == READY;
`ifdef DMEM_WRFWD_EN
  assign rd_word = memwrite ? writedata : mem[address];
`else
  assign rd_word = mem[address];
`endif
  // array writes: the clear sweep owns the array until READY, then the port does; nothing is written while RESET is held
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (state == CLEAR) mem[clr_ptr] <= INIT_VALUE;
      else if (memwrite) mem[address] <= writedata;
    end
  end
  // sweep FSM and registered read port; reset drops any in-flight read
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= CLEAR;
      clr_ptr <= '0;
      readdata <= '0;
      readvalid <= 1'b0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      state <= &clr_ptr ? READY : CLEAR;
      readvalid <= 1'b0;
    end else begin
      readvalid <= memread;
      if (memread) readdata <= rd_word;
    end
  end
endmodule
